// File: rtl/sumador_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package sumador_pkg;

   localparam int SUMADOR_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sumador_fa.sv
// One-bit full adder cell used by the serial adder datapath.
// Purely combinational.
module sumador_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/sumador_serial.sv
// Bit-serial adder, LSB first, one bit per clock.
// Define SUMADOR_SUB_EN to enable subtract mode through the sub port.
module sumador_serial
   import sumador_pkg::*;
#(
   parameter int WIDTH = SUMADOR_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] b_eff;
   logic             c_eff;
   logic             fa_s;
   logic             fa_co;

`ifdef SUMADOR_SUB_EN
   // Subtraction as a + ~b + 1: invert b and force the carry-in.
   assign b_eff = sub ? ~b : b;
   assign c_eff = sub ? 1'b1 : cin;
`else
   logic sub_unused;
   assign sub_unused = sub;
   assign b_eff      = b;
   assign c_eff      = cin;
`endif

   sumador_fa u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (cnt == LAST) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b_eff;
                  carry <= c_eff;
                  cnt   <= '0;
                  sum   <= '0;
                  cout  <= 1'b0;
                  ovf   <= 1'b0;
               end
            end
            RUN: begin
               sum   <= {fa_s, sum[WIDTH-1:1]};
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               carry <= fa_co;
               cnt   <= cnt + 1'b1;
               // On the MSB step carry holds the carry into the MSB.
               if (cnt == LAST) begin
                  cout <= fa_co;
                  ovf  <= carry ^ fa_co;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule
